// File: rtl/pattern_seq_ctrl.sv
// Programmable serial pattern sequencer: one-shot/looped, start/stop/pause, all outputs registered.
// Latency: oSIG follows a start or step one clock later; no backpressure, config writes while busy are rejected.
module pattern_seq_ctrl #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 4,
  // 24 bits so the 12499999 reset divider is representable
  parameter int DIV_W = 24,
  parameter logic [PAT_W-1:0] DEF_PAT = 16'h00ED,
  parameter logic [LEN_W-1:0] DEF_LEN = 4'd9,
  parameter logic [DIV_W-1:0] DEF_DIV = 24'd12499999
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iCFG_WR,
  input  logic [PAT_W-1:0] iCFG_PAT,
  input  logic [LEN_W-1:0] iCFG_LEN,
  input  logic [DIV_W-1:0] iCFG_DIV,
  input  logic             iCFG_LOOP,
  input  logic             iSTART,
  input  logic             iSTOP,
  input  logic             iPAUSE,
  output logic             oSIG,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [LEN_W-1:0] oIDX,
  output logic             oCFG_ERR
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               loop_q, loop_d;
  logic [DIV_W-1:0]   pre_q, pre_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               sig_q, sig_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [LEN_W-1:0]   len_clamp;
  logic [LEN_W-1:0]   idx_nxt;
  logic [PAT_W-1:0]   pat_sh;

  always_comb begin
    len_clamp = iCFG_LEN;
    if (32'(iCFG_LEN) > PAT_W - 1) begin
      len_clamp = LEN_W'(PAT_W - 1);
    end
    idx_nxt = idx_q + 1'b1;
    // shift rather than index so a wide LEN_W never selects past the pattern
    pat_sh  = pat_q >> idx_nxt;
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    div_d   = div_q;
    loop_d  = loop_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    sig_d   = sig_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (iCFG_WR) begin
          pat_d  = iCFG_PAT;
          len_d  = len_clamp;
          div_d  = iCFG_DIV;
          loop_d = iCFG_LOOP;
        end
        if (iSTART && !iSTOP) begin
          state_d = RUN;
          pre_d   = '0;
          idx_d   = '0;
          sig_d   = pat_d[0];
        end
      end

      RUN, PAUSE: begin
        err_d = iCFG_WR;
        if (iSTOP) begin
          state_d = IDLE;
          pre_d   = '0;
          idx_d   = '0;
          sig_d   = 1'b0;
        end else if (iPAUSE) begin
          state_d = PAUSE;
        end else begin
          // the release edge counts too, so paused runs keep div+1 active clocks per index
          state_d = RUN;
          if (pre_q == div_q) begin
            pre_d = '0;
            if (idx_q < len_q) begin
              idx_d = idx_nxt;
              sig_d = pat_sh[0];
            end else if (loop_q) begin
              idx_d = '0;
              sig_d = pat_q[0];
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
              idx_d   = '0;
              sig_d   = 1'b0;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      pat_q   <= DEF_PAT;
      len_q   <= DEF_LEN;
      div_q   <= DEF_DIV;
      loop_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      sig_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      div_q   <= div_d;
      loop_q  <= loop_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign oSIG     = sig_q;
  assign oBUSY    = (state_q != IDLE);
  assign oDONE    = done_q;
  assign oIDX     = idx_q;
  assign oCFG_ERR = err_q;

endmodule
